// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage; drives a level-held imem request/ack handshake and fills the IF/ID register.
// Latency: IF/ID loads on the edge that sees imem_ack (zero-wait memory gives one instruction per cycle).
// Backpressure: stall holds PC and IF/ID; an ack under stall parks in a one-entry skid (HOLD) with imem_req low.
// Ports: clk/rst_n; PcSrc, kill, stall, jmp_target, br_target, ret_addr (redirect control from decode);
//        imem_req/imem_addr out, imem_ack/imem_rdata in; if_instr/if_pc/if_pc_plus1/if_valid (IF/ID);
//        fetch_err (sticky timeout flag). Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_killed.
module fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          IMEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PcSrc,
  input  logic        kill,
  input  logic        stall,
  input  logic [15:0] jmp_target,
  input  logic [15:0] br_target,
  input  logic [15:0] ret_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus1,
  output logic        if_valid,
  output logic        fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
`endif
);

  localparam int            CW  = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(IMEM_TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
  } ifid_t;

  state_t        state, state_nxt;
  logic [15:0]   pc, pc_nxt, pc_inc, redirect_pc;
  logic [15:0]   dis_addr, skid_instr;
  logic          discard, discard_nxt;
  logic          dis_ld, skid_ld, load_ifid, load_from_skid, clr_valid;
  ifid_t         ifid;
  logic          ifid_vld;
  logic [CW-1:0] tmo_cnt;
  logic          err;

  assign pc_inc = pc + 16'd1;

  always_comb begin
    redirect_pc = pc_inc;
    case (PcSrc)
      2'd0:    redirect_pc = pc_inc;
      2'd1:    redirect_pc = jmp_target;
      2'd2:    redirect_pc = br_target;
      default: redirect_pc = ret_addr;
    endcase
  end

  assign imem_req = (state == REQ);
  // After a kill the old request is still on the bus until its ack returns;
  // keep presenting its address so the handshake stays stable.
  assign imem_addr = discard ? dis_addr : pc;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    discard_nxt    = discard;
    dis_ld         = 1'b0;
    skid_ld        = 1'b0;
    load_ifid      = 1'b0;
    load_from_skid = 1'b0;
    clr_valid      = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (kill) begin
          pc_nxt    = redirect_pc;
          clr_valid = 1'b1;
        end
      end
      REQ: begin
        if (kill) begin
          pc_nxt    = redirect_pc;
          clr_valid = 1'b1;
          if (imem_ack) begin
            discard_nxt = 1'b0;
          end else if (!discard) begin
            discard_nxt = 1'b1;
            dis_ld      = 1'b1;
          end
        end else if (imem_ack) begin
          if (discard) begin
            discard_nxt = 1'b0;
          end else if (stall) begin
            // PC stays put; the skid entry belongs to the current PC.
            skid_ld   = 1'b1;
            state_nxt = HOLD;
          end else begin
            load_ifid = 1'b1;
            pc_nxt    = redirect_pc;
          end
        end
      end
      HOLD: begin
        if (kill) begin
          pc_nxt    = redirect_pc;
          clr_valid = 1'b1;
          state_nxt = REQ;
        end else if (!stall) begin
          load_ifid      = 1'b1;
          load_from_skid = 1'b1;
          pc_nxt         = redirect_pc;
          state_nxt      = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      dis_addr   <= 16'h0000;
      skid_instr <= 16'h0000;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
      if (dis_ld)  dis_addr   <= pc;
      if (skid_ld) skid_instr <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid     <= '0;
      ifid_vld <= 1'b0;
    end else if (clr_valid) begin
      ifid_vld <= 1'b0;
    end else if (load_ifid) begin
      ifid.instr    <= load_from_skid ? skid_instr : imem_rdata;
      ifid.pc       <= pc;
      ifid.pc_plus1 <= pc_inc;
      ifid_vld      <= 1'b1;
    end else if (!stall) begin
      ifid_vld <= 1'b0;
    end
  end

  // Counts consecutive unanswered request cycles; the error is sticky but
  // the request simply keeps waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else if (imem_req && !imem_ack) begin
      if (tmo_cnt != TMO)         tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_cnt >= TMO - 1'b1)  err     <= 1'b1;
    end else if (imem_req) begin
      tmo_cnt <= '0;
    end
  end

  assign if_instr    = ifid.instr;
  assign if_pc       = ifid.pc;
  assign if_pc_plus1 = ifid.pc_plus1;
  assign if_valid    = ifid_vld;
  assign fetch_err   = err;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_killed  <= 32'd0;
    end else begin
      if (load_ifid && !clr_valid && (perf_fetched != 32'hFFFF_FFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (kill && (perf_killed != 32'hFFFF_FFFF))
        perf_killed <= perf_killed + 32'd1;
    end
  end
`endif

endmodule
